mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one `mult` signed 16x16 multiplier between `N_CLI` independent requesters. It accepts one operand pair per grant and drives the multiplier's `req`/`ack`/`result_rdy` handshake. It then routes the 32-bit result, result parity and argument-parity-error flag back to the winning client. It sits between the client blocks and the multiplier, and is the only master of the multiplier's input bus.

---
 rtl/mult_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one signed 16x16 multiplier among N_CLI clients.
// Define MULT_ARB_TIMEOUT_EN to enable the per-operation watchdog abort.
module mult_arbiter #(
    parameter int N_CLI          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CLI-1:0]      cli_req,
    input  logic [16*N_CLI-1:0]   cli_arg_a,
    input  logic [N_CLI-1:0]      cli_arg_a_parity,
    input  logic [16*N_CLI-1:0]   cli_arg_b,
    input  logic [N_CLI-1:0]      cli_arg_b_parity,
    output logic [N_CLI-1:0]      cli_gnt,
    output logic [N_CLI-1:0]      cli_done,
    output logic [31:0]           cli_result,
    output logic                  cli_result_parity,
    output logic                  cli_parity_error,
    output logic                  cli_timeout,
    output logic [15:0]           mult_arg_a,
    output logic [15:0]           mult_arg_b,
    output logic                  mult_arg_a_parity,
    output logic                  mult_arg_b_parity,
    output logic                  mult_req,
    input  logic                  mult_ack,
    input  logic [31:0]           mult_result,
    input  logic                  mult_result_parity,
    input  logic                  mult_arg_parity_error,
    input  logic                  mult_result_rdy
);
    localparam int PTR_W = $clog2(N_CLI);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [N_CLI-1:0]  cli_gnt_q, cli_gnt_d;
    logic [N_CLI-1:0]  cli_done_q, cli_done_d;
    logic [31:0]       cli_result_q, cli_result_d;
    logic              cli_result_parity_q, cli_result_parity_d;
    logic              cli_parity_error_q, cli_parity_error_d;
    logic              cli_timeout_q, cli_timeout_d;
    logic [15:0]       mult_arg_a_q, mult_arg_a_d;
    logic [15:0]       mult_arg_b_q, mult_arg_b_d;
    logic              mult_arg_a_parity_q, mult_arg_a_parity_d;
    logic              mult_arg_b_parity_q, mult_arg_b_parity_d;
    logic              mult_req_q, mult_req_d;

    logic              found;
    logic [PTR_W-1:0]  winner;
    logic [15:0]       sel_a, sel_b;
    logic              sel_a_par, sel_b_par;
    logic              do_capture, do_abort;
    logic              tmo_hit;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == ISSUE || state_q == WAIT_RES) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE)
            tmo_cnt_d = '0;
        else if (state_q == ISSUE || state_q == WAIT_RES)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Two passes: requesters at or above rr_ptr first, then wrap to the low indices.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        for (int i = 0; i < N_CLI; i++) begin
            if (!found && cli_req[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_CLI; i++) begin
            if (!found && cli_req[i]) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_a_par = 1'b0;
        sel_b_par = 1'b0;
        for (int i = 0; i < N_CLI; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_a     = cli_arg_a[16*i +: 16];
                sel_b     = cli_arg_b[16*i +: 16];
                sel_a_par = cli_arg_a_parity[i];
                sel_b_par = cli_arg_b_parity[i];
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        owner_d             = owner_q;
        cli_gnt_d           = '0;
        cli_done_d          = '0;
        cli_result_d        = cli_result_q;
        cli_result_parity_d = cli_result_parity_q;
        cli_parity_error_d  = cli_parity_error_q;
        cli_timeout_d       = cli_timeout_q;
        mult_arg_a_d        = mult_arg_a_q;
        mult_arg_b_d        = mult_arg_b_q;
        mult_arg_a_parity_d = mult_arg_a_parity_q;
        mult_arg_b_parity_d = mult_arg_b_parity_q;
        mult_req_d          = mult_req_q;
        do_capture          = 1'b0;
        do_abort            = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    mult_arg_a_d        = sel_a;
                    mult_arg_b_d        = sel_b;
                    mult_arg_a_parity_d = sel_a_par;
                    mult_arg_b_parity_d = sel_b_par;
                    mult_req_d          = 1'b1;
                    cli_gnt_d[winner]   = 1'b1;
                    owner_d             = winner;
                    rr_ptr_d            = (winner == PTR_W'(N_CLI - 1)) ? '0 : winner + 1'b1;
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                if (mult_ack) begin
                    mult_req_d = 1'b0;
                    if (mult_result_rdy) do_capture = 1'b1;
                    else                 state_d    = WAIT_RES;
                end else if (tmo_hit) begin
                    do_abort = 1'b1;
                end
            end
            WAIT_RES: begin
                if (mult_result_rdy) do_capture = 1'b1;
                else if (tmo_hit)    do_abort   = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (do_capture) begin
            cli_result_d         = mult_result;
            cli_result_parity_d  = mult_result_parity;
            cli_parity_error_d   = mult_arg_parity_error;
            cli_timeout_d        = 1'b0;
            cli_done_d[owner_q]  = 1'b1;
            state_d              = RESP;
        end
        if (do_abort) begin
            mult_req_d           = 1'b0;
            cli_result_d         = '0;
            cli_result_parity_d  = 1'b0;
            cli_parity_error_d   = 1'b0;
            cli_timeout_d        = 1'b1;
            cli_done_d[owner_q]  = 1'b1;
            state_d              = RESP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            owner_q             <= '0;
            cli_gnt_q           <= '0;
            cli_done_q          <= '0;
            cli_result_q        <= '0;
            cli_result_parity_q <= 1'b0;
            cli_parity_error_q  <= 1'b0;
            cli_timeout_q       <= 1'b0;
            mult_arg_a_q        <= '0;
            mult_arg_b_q        <= '0;
            mult_arg_a_parity_q <= 1'b0;
            mult_arg_b_parity_q <= 1'b0;
            mult_req_q          <= 1'b0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            owner_q             <= owner_d;
            cli_gnt_q           <= cli_gnt_d;
            cli_done_q          <= cli_done_d;
            cli_result_q        <= cli_result_d;
            cli_result_parity_q <= cli_result_parity_d;
            cli_parity_error_q  <= cli_parity_error_d;
            cli_timeout_q       <= cli_timeout_d;
            mult_arg_a_q        <= mult_arg_a_d;
            mult_arg_b_q        <= mult_arg_b_d;
            mult_arg_a_parity_q <= mult_arg_a_parity_d;
            mult_arg_b_parity_q <= mult_arg_b_parity_d;
            mult_req_q          <= mult_req_d;
        end
    end

    assign cli_gnt           = cli_gnt_q;
    assign cli_done          = cli_done_q;
    assign cli_result        = cli_result_q;
    assign cli_result_parity = cli_result_parity_q;
    assign cli_parity_error  = cli_parity_error_q;
    assign cli_timeout       = cli_timeout_q;
    assign mult_arg_a        = mult_arg_a_q;
    assign mult_arg_b        = mult_arg_b_q;
    assign mult_arg_a_parity = mult_arg_a_parity_q;
    assign mult_arg_b_parity = mult_arg_b_parity_q;
    assign mult_req          = mult_req_q;
endmodule
